// File: rtl/demux4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// channel index type and the named channel constants.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    localparam ch_idx_t CH_A = 2'd0;
    localparam ch_idx_t CH_B = 2'd1;
    localparam ch_idx_t CH_C = 2'd2;
    localparam ch_idx_t CH_D = 2'd3;

    // Expands a channel index into a one-hot channel mask.
    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_idx_t ch);
        logic [NUM_CH-1:0] mask;
        mask     = '0;
        mask[ch] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// Handshake bundle of the demultiplexer: one valid/ready input stream, four
// valid/ready output channels and the status outputs.
interface demux4_stream_if
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    ch_idx_t           in_sel;
    logic              rr_mode;

    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [WIDTH-1:0]  out_data_a;
    logic [WIDTH-1:0]  out_data_b;
    logic [WIDTH-1:0]  out_data_c;
    logic [WIDTH-1:0]  out_data_d;

    ch_idx_t           rr_ptr;
    logic [CNT_W-1:0]  xfer_cnt;

    // Producer and consumers side: drives the input stream and the output readies.
    modport master (
        output in_valid, in_data, in_sel, rr_mode, out_ready,
        input  in_ready, out_valid, out_data_a, out_data_b, out_data_c, out_data_d,
        input  rr_ptr, xfer_cnt
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_data, in_sel, rr_mode, out_ready,
        output in_ready, out_valid, out_data_a, out_data_b, out_data_c, out_data_d,
        output rr_ptr, xfer_cnt
    );

endinterface

// File: rtl/demux4_stream_slot.sv
// One-entry holding register for a single output channel. A push in the same
// cycle as a pop replaces the word and keeps the channel valid.
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_push
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Free either when empty or when the consumer drains it this cycle.
    assign can_push = !valid_q || pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            data_q  <= push_data;
        end else if (valid_q && pop_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 registered stream demultiplexer: routes each accepted word to the
// channel chosen by in_sel or by the round-robin pointer.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    demux4_stream_if.slave bus
);

    ch_idx_t           tgt;
    ch_idx_t           rr_ptr_q;
    logic [CNT_W-1:0]  xfer_cnt_q;
    logic              in_ready_int;
    logic              accept;
    logic [NUM_CH-1:0] slot_push;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_can_push;
    logic [WIDTH-1:0]  slot_data [NUM_CH];

    // A blocked target stalls the input; there is deliberately no skipping
    // ahead to another free channel in round-robin mode.
    always_comb begin
        tgt          = bus.rr_mode ? rr_ptr_q : bus.in_sel;
        in_ready_int = !rst && slot_can_push[tgt];
        accept       = bus.in_valid && in_ready_int;
        slot_push    = sel_onehot(tgt) & {NUM_CH{accept}};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .push     (slot_push[i]),
            .push_data(bus.in_data),
            .pop_ready(bus.out_ready[i]),
            .valid    (slot_valid[i]),
            .data     (slot_data[i]),
            .can_push (slot_can_push[i])
        );
    end

    // The pointer only moves on round-robin accepts, so it survives mode switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= CH_A;
            xfer_cnt_q <= '0;
        end else if (accept) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            if (bus.rr_mode) begin
                rr_ptr_q <= rr_ptr_q + 2'd1;
            end
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = slot_valid;
    assign bus.out_data_a = slot_data[CH_A];
    assign bus.out_data_b = slot_data[CH_B];
    assign bus.out_data_c = slot_data[CH_C];
    assign bus.out_data_d = slot_data[CH_D];
    assign bus.rr_ptr     = rr_ptr_q;
    assign bus.xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus random traffic
// compared against a per-channel occupancy model.
module tb_demux4_stream;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bit          m_valid [4];
    logic [31:0] m_data  [4];
    int          m_ptr;
    int          m_cnt;

    demux4_stream_if #(.WIDTH(32), .CNT_W(16)) bus ();

    demux4_stream #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dut_data(input int ch);
        case (ch)
            0:       return bus.out_data_a;
            1:       return bus.out_data_b;
            2:       return bus.out_data_c;
            default: return bus.out_data_d;
        endcase
    endfunction

    function automatic int m_tgt();
        return bus.rr_mode ? m_ptr : int'(bus.in_sel);
    endfunction

    function automatic bit m_ready();
        int t;
        t = m_tgt();
        return !rst && (!m_valid[t] || bus.out_ready[t]);
    endfunction

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_valid[i];
        return v;
    endfunction

    // Advances the model by one clock using the inputs presented now, then
    // waits for the edge and settles just after it.
    task automatic tick();
        int t;
        bit acc;
        t   = m_tgt();
        acc = bus.in_valid && m_ready();
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 0;
                m_data[i]  = '0;
            end
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && i == t) begin
                    m_valid[i] = 1;
                    m_data[i]  = bus.in_data;
                end else if (m_valid[i] && bus.out_ready[i]) begin
                    m_valid[i] = 0;
                end
            end
            if (acc) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (bus.rr_mode) m_ptr = (m_ptr + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sel   = 2'd0;
        bus.rr_mode  = 1'b0;
        bus.out_ready = 4'b0000;
        tick();
        tick();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0000", bus.out_valid);
        end
        total++;
        if (bus.rr_ptr !== 2'd0 || bus.xfer_cnt !== 16'd0) begin
            bad++; $display("[TB] FAIL reset_ptr_cnt got=%0d/%0d exp=0/0", bus.rr_ptr, bus.xfer_cnt);
        end
        total++;
        if (bus.out_data_a !== 32'd0 || bus.out_data_d !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", bus.out_data_a, bus.out_data_d);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_directed();
        bus.rr_mode   = 1'b0;
        bus.in_sel    = 2'd2;
        bus.in_data   = 32'hDEADBEEF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b0000;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0100 || bus.out_data_c !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL single_word got=%b/%h exp=0100/deadbeef", bus.out_valid, bus.out_data_c);
        end
        total++;
        if (bus.xfer_cnt !== 16'd1) begin
            bad++; $display("[TB] FAIL single_cnt got=%0d exp=1", bus.xfer_cnt);
        end
        bus.in_data  = 32'hCAFEF00D;
        bus.in_valid = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL full_blocks got=%b exp=0", bus.in_ready);
        end
        tick();
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_data_c !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL full_holds got=%b/%h exp=0/deadbeef", bus.in_ready, bus.out_data_c);
        end
        bus.out_ready = 4'b0100;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL pop_frees got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        total++;
        if (bus.out_valid !== 4'b0100 || bus.out_data_c !== 32'hCAFEF00D || bus.xfer_cnt !== 16'd2) begin
            bad++; $display("[TB] FAIL replace got=%b/%h/%0d exp=0100/cafef00d/2",
                            bus.out_valid, bus.out_data_c, bus.xfer_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 4'b0100;
        bus.in_sel    = 2'd1;
        bus.in_data   = 32'h0;
        bus.in_valid  = 1'b1;
        tick();
        bus.out_ready = 4'b0010;
        for (int w = 1; w <= 3; w++) begin
            bus.in_data = 32'(w);
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL b2b_ready word=%0d got=%b exp=1", w, bus.in_ready);
            end
            tick();
            total++;
            if (bus.out_valid[1] !== 1'b1 || bus.out_data_b !== 32'(w)) begin
                bad++; $display("[TB] FAIL b2b_data word=%0d got=%b/%h exp=1/%h",
                                w, bus.out_valid[1], bus.out_data_b, 32'(w));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        tick();
        total++;
        if (bus.out_valid !== 4'b0000) begin
            bad++; $display("[TB] FAIL b2b_drain got=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_round_robin();
        bus.rr_mode   = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_sel  = 2'($urandom_range(0, 3));
            bus.in_data = 32'(10 + i);
            #1;
            total++;
            if (bus.rr_ptr !== 2'(i % 4) || bus.in_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL rr_ptr step=%0d got=%0d/%b exp=%0d/1", i, bus.rr_ptr, bus.in_ready, i % 4);
            end
            tick();
            total++;
            if (bus.out_valid[i % 4] !== 1'b1 || dut_data(i % 4) !== 32'(10 + i)) begin
                bad++; $display("[TB] FAIL rr_route step=%0d got=%b/%h exp=1/%h",
                                i, bus.out_valid[i % 4], dut_data(i % 4), 32'(10 + i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (bus.rr_ptr !== 2'd2) begin
            bad++; $display("[TB] FAIL rr_final_ptr got=%0d exp=2", bus.rr_ptr);
        end
    endtask

    task automatic test_rr_stall();
        bus.rr_mode   = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        tick();
        bus.rr_mode   = 1'b0;
        bus.in_sel    = 2'd1;
        bus.out_ready = 4'b0000;
        bus.in_data   = 32'h0000B0B0;
        bus.in_valid  = 1'b1;
        tick();
        total++;
        if (bus.rr_ptr !== 2'd1 || bus.out_valid !== 4'b0010) begin
            bad++; $display("[TB] FAIL stall_setup got=%0d/%b exp=1/0010", bus.rr_ptr, bus.out_valid);
        end
        bus.rr_mode   = 1'b1;
        bus.in_sel    = 2'd3;
        bus.out_ready = 4'b1101;
        bus.in_data   = 32'h00005A5A;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_ready got=%b exp=0", bus.in_ready);
        end
        repeat (3) begin
            tick();
            total++;
            if (bus.rr_ptr !== 2'd1 || bus.out_data_b !== 32'h0000B0B0 || bus.out_valid !== 4'b0010) begin
                bad++; $display("[TB] FAIL stall_hold got=%0d/%h/%b exp=1/0000b0b0/0010",
                                bus.rr_ptr, bus.out_data_b, bus.out_valid);
            end
        end
        bus.out_ready = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_release got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_data_b !== 32'h00005A5A || bus.out_valid[1] !== 1'b1 || bus.rr_ptr !== 2'd2) begin
            bad++; $display("[TB] FAIL stall_deliver got=%h/%b/%0d exp=00005a5a/1/2",
                            bus.out_data_b, bus.out_valid[1], bus.rr_ptr);
        end
        total++;
        if (bus.xfer_cnt !== 16'(m_cnt)) begin
            bad++; $display("[TB] FAIL stall_cnt got=%0d exp=%0d", bus.xfer_cnt, m_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.rr_mode   = 1'($urandom_range(0, 1));
            bus.out_ready = 4'($urandom);
            #1;
            total++;
            if (bus.in_ready !== m_ready()) begin
                bad++; $display("[TB] FAIL rand_ready n=%0d got=%b exp=%b", n, bus.in_ready, m_ready());
            end
            tick();
            total++;
            if (bus.out_valid !== m_valid_vec() || bus.rr_ptr !== 2'(m_ptr) || bus.xfer_cnt !== 16'(m_cnt)) begin
                bad++; $display("[TB] FAIL rand_state n=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", n,
                                bus.out_valid, bus.rr_ptr, bus.xfer_cnt, m_valid_vec(), m_ptr, m_cnt);
            end
            for (int c = 0; c < 4; c++) begin
                total++;
                if (dut_data(c) !== m_data[c]) begin
                    bad++; $display("[TB] FAIL rand_data n=%0d ch=%0d got=%h exp=%h", n, c, dut_data(c), m_data[c]);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.rr_mode   = 1'b1;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        tick();
        bus.rr_mode   = 1'b0;
        bus.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel  = 2'(i);
            bus.in_data = 32'h1000 + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 4'b1111 || bus.rr_ptr === 2'd0) begin
            bad++; $display("[TB] FAIL midrst_setup got=%b/%0d exp=1111/nonzero", bus.out_valid, bus.rr_ptr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_ready_low got=%b exp=0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        total++;
        if (bus.out_valid !== 4'b0000 || bus.rr_ptr !== 2'd0 || bus.xfer_cnt !== 16'd0) begin
            bad++; $display("[TB] FAIL midrst_state got=%b/%0d/%0d exp=0000/0/0",
                            bus.out_valid, bus.rr_ptr, bus.xfer_cnt);
        end
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL midrst_ready_high got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_counter_wrap();
        bus.rr_mode   = 1'b0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            bus.in_data = 32'(k);
            tick();
        end
        total++;
        if (bus.xfer_cnt !== 16'hFFFF) begin
            bad++; $display("[TB] FAIL cnt_max got=%h exp=ffff", bus.xfer_cnt);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.xfer_cnt !== 16'h0000 || bus.xfer_cnt !== 16'(m_cnt)) begin
            bad++; $display("[TB] FAIL cnt_wrap got=%h exp=0000", bus.xfer_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_data[i]  = '0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_round_robin();
        test_rr_stall();
        test_random();
        test_mid_reset();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
